// File: rtl/keycode_event_ctrl.sv
// rtl/keycode_event_ctrl.sv - turns a held PIO keycode into PRESS/REPEAT/RELEASE events behind a FWFT FIFO
module keycode_event_ctrl #(
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] keycode,
  input  logic       evt_ready,
  input  logic       clear_overflow,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic [1:0] evt_kind,
  output logic       overflow
);

  localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;
  localparam int AW   = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] KIND_PRESS   = 2'b00;
  localparam logic [1:0] KIND_REPEAT  = 2'b01;
  localparam logic [1:0] KIND_RELEASE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      cur_code_q, cur_code_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            key_down;
  logic            key_lost;
  logic            hold_due;
  logic            rep_due;

  logic            emit;
  logic [1:0]      emit_kind;
  logic [7:0]      emit_code;

  logic [9:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [AW:0]     count_q;
  logic            overflow_q;
  logic            fifo_full;
  logic            pop;
  logic            do_push;
  logic            drop;

  assign key_down = (keycode != 8'h00);
  assign key_lost = (keycode != cur_code_q);
  assign hold_due = (cnt_q == CW'(HOLD_CYCLES - 1));
  assign rep_due  = (cnt_q == CW'(REPEAT_CYCLES - 1));

  // FSM state and key-tracking registers; reset drops any held key silently
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cur_code_q <= 8'h00;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cur_code_q <= cur_code_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state: any deviation from the held code ends the hold, taking priority over a due repeat
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (key_down) state_d = S_DELAY;
      S_DELAY: begin
        if (key_lost)      state_d = S_IDLE;
        else if (hold_due) state_d = S_REPEAT;
      end
      S_REPEAT: if (key_lost) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: at most one event per cycle plus the counter/code bookkeeping
  always_comb begin
    emit       = 1'b0;
    emit_kind  = KIND_PRESS;
    emit_code  = cur_code_q;
    cur_code_d = cur_code_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (key_down) begin
          emit       = 1'b1;
          emit_kind  = KIND_PRESS;
          emit_code  = keycode;
          cur_code_d = keycode;
          cnt_d      = '0;
        end
      end
      S_DELAY, S_REPEAT: begin
        if (key_lost) begin
          emit       = 1'b1;
          emit_kind  = KIND_RELEASE;
          cur_code_d = 8'h00;
          cnt_d      = '0;
        end else if ((state_q == S_DELAY) ? hold_due : rep_due) begin
          emit      = 1'b1;
          emit_kind = KIND_REPEAT;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cur_code_d = 8'h00;
        cnt_d      = '0;
      end
    endcase
  end

  // A push into a full FIFO is still allowed when the head leaves the same cycle
  assign fifo_full = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign evt_valid = (count_q != '0);
  assign pop       = evt_valid & evt_ready;
  assign do_push   = emit & (~fifo_full | pop);
  assign drop      = emit & fifo_full & ~pop;

  // Event storage is data-only; emptiness is tracked by count_q so it needs no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {emit_kind, emit_code};
  end

  // FIFO pointers, occupancy and the sticky drop flag (a drop beats a clear)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      case ({do_push, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
      if (drop)                overflow_q <= 1'b1;
      else if (clear_overflow) overflow_q <= 1'b0;
    end
  end

  assign evt_code = evt_valid ? mem_q[rd_ptr_q][7:0] : 8'h00;
  assign evt_kind = evt_valid ? mem_q[rd_ptr_q][9:8] : 2'b00;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_keycode_event_ctrl.sv
// tb/tb_keycode_event_ctrl.sv - randomized and directed checks of keycode_event_ctrl against a queue model
module tb_keycode_event_ctrl;

  localparam int H = 4;
  localparam int R = 2;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] keycode = 8'h00;
  logic       evt_ready = 1'b1;
  logic       clear_overflow = 1'b0;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic [1:0] evt_kind;
  logic       overflow;

  keycode_event_ctrl #(
    .HOLD_CYCLES  (H),
    .REPEAT_CYCLES(R),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .keycode       (keycode),
    .evt_ready     (evt_ready),
    .clear_overflow(clear_overflow),
    .evt_valid     (evt_valid),
    .evt_code      (evt_code),
    .evt_kind      (evt_kind),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic [1:0] kind;
  } ev_t;

  int         checks = 0;
  int         errors = 0;
  ev_t        q[$];
  logic       m_ov;
  logic [7:0] m_cur;
  int         m_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ov  = 1'b0;
    m_cur = 8'h00;
    m_t   = 0;
  endtask

  // Key behaviour from elapsed time since press, then a bounded queue
  task automatic model_edge();
    bit  emit;
    ev_t e;
    bit  pop;
    emit = 0;
    e    = '0;
    if (m_cur == 8'h00) begin
      if (keycode != 8'h00) begin
        emit = 1; e.code = keycode; e.kind = 2'd0;
        m_cur = keycode; m_t = 0;
      end
    end else if (keycode != m_cur) begin
      emit = 1; e.code = m_cur; e.kind = 2'd2;
      m_cur = 8'h00;
    end else begin
      m_t++;
      if (m_t >= H && ((m_t - H) % R) == 0) begin
        emit = 1; e.code = m_cur; e.kind = 2'd1;
      end
    end
    pop = evt_ready && (q.size() > 0);
    if (pop) void'(q.pop_front());
    if (clear_overflow) m_ov = 1'b0;
    if (emit) begin
      if (q.size() < D) q.push_back(e);
      else m_ov = 1'b1;
    end
  endtask

  task automatic compare();
    chk("valid", int'(evt_valid), int'(q.size() > 0));
    if (q.size() > 0) begin
      chk("code", int'(evt_code), int'(q[0].code));
      chk("kind", int'(evt_kind), int'(q[0].kind));
    end else begin
      chk("code_empty", int'(evt_code), 0);
      chk("kind_empty", int'(evt_kind), 0);
    end
    chk("overflow", int'(overflow), int'(m_ov));
  endtask

  task automatic step(input logic [7:0] k, input logic rdy, input logic clr);
    keycode        = k;
    evt_ready      = rdy;
    clear_overflow = clr;
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
    compare();
  endtask

  // exp_kind < 0 means no event presented
  task automatic lit(input string name, input int exp_kind, input int exp_code);
    if (exp_kind < 0) begin
      chk({name, "_valid"}, int'(evt_valid), 0);
    end else begin
      chk({name, "_valid"}, int'(evt_valid), 1);
      chk({name, "_kind"}, int'(evt_kind), exp_kind);
      chk({name, "_code"}, int'(evt_code), exp_code);
    end
  endtask

  initial begin
    logic [7:0] keys [4];
    logic [7:0] k;
    int         hk;
    keys[0] = 8'h00; keys[1] = 8'h11; keys[2] = 8'h22; keys[3] = 8'h5A;

    // Reset with a key already down
    model_reset();
    keycode = 8'h1A;
    #2 reset_n = 1'b0;
    #2;
    lit("rst", -1, 0);
    chk("rst_ov", int'(overflow), 0);
    chk("rst_code", int'(evt_code), 0);
    chk("rst_kind", int'(evt_kind), 0);
    repeat (2) @(posedge clk);
    #1;
    lit("rst_hold", -1, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step(8'h1A, 1'b1, 1'b0); lit("rst_press", 0, 8'h1A);
    step(8'h00, 1'b1, 1'b0); lit("rst_rel", 2, 8'h1A);
    step(8'h00, 1'b1, 1'b0); lit("rst_idle", -1, 0);

    // Tap
    step(8'h1A, 1'b1, 1'b0); lit("tap_press", 0, 8'h1A);
    step(8'h00, 1'b1, 1'b0); lit("tap_rel", 2, 8'h1A);
    step(8'h00, 1'b1, 1'b0); lit("tap_done", -1, 0);

    // Hold: events at edges 0,4,6,8,10
    for (int i = 0; i <= 10; i++) begin
      step((i < 10) ? 8'h04 : 8'h00, 1'b1, 1'b0);
      if (i == 0)                      lit("hold_press", 0, 8'h04);
      else if (i == 4 || i == 6 || i == 8) lit("hold_rep", 1, 8'h04);
      else if (i == 10)                lit("hold_rel", 2, 8'h04);
      else                             lit("hold_gap", -1, 0);
    end
    step(8'h00, 1'b1, 1'b0); lit("hold_done", -1, 0);

    // Direct key change
    step(8'h04, 1'b1, 1'b0); lit("chg_press", 0, 8'h04);
    step(8'h04, 1'b1, 1'b0); lit("chg_gap", -1, 0);
    step(8'h05, 1'b1, 1'b0); lit("chg_rel", 2, 8'h04);
    step(8'h05, 1'b1, 1'b0); lit("chg_press2", 0, 8'h05);
    step(8'h00, 1'b1, 1'b0); lit("chg_rel2", 2, 8'h05);
    step(8'h00, 1'b1, 1'b0); lit("chg_done", -1, 0);

    // Backpressure: six events into four slots
    step(8'h1A, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h1B, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h1C, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    lit("bp_head", 0, 8'h1A);
    chk("bp_ov_set", int'(overflow), 1);
    step(8'h00, 1'b0, 1'b1);
    chk("bp_ov_clr", int'(overflow), 0);
    step(8'h2B, 1'b1, 1'b0); lit("bp_full_pp", 2, 8'h1A);
    chk("bp_no_drop", int'(overflow), 0);
    step(8'h2B, 1'b1, 1'b0); lit("bp_d2", 0, 8'h1B);
    step(8'h2B, 1'b1, 1'b0); lit("bp_d3", 2, 8'h1B);
    step(8'h2B, 1'b1, 1'b0); lit("bp_d4", 0, 8'h2B);
    step(8'h00, 1'b1, 1'b0); lit("bp_d5", 2, 8'h2B);
    step(8'h00, 1'b1, 1'b0); lit("bp_empty", -1, 0);

    // Reset while repeating with three queued events
    for (int i = 0; i < 7; i++) step(8'h33, 1'b0, 1'b0);
    lit("mid_head", 0, 8'h33);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    lit("mid_rst", -1, 0);
    chk("mid_rst_ov", int'(overflow), 0);
    keycode = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    step(8'h00, 1'b1, 1'b0); lit("mid_after", -1, 0);

    // Randomized traffic
    k = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        #1;
        compare();
        @(negedge clk);
        reset_n = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) begin
        hk = int'($urandom_range(0, 3));
        k = keys[hk];
      end
      step(k, ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
           ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keycode_event_ctrl.md
# keycode_event_ctrl

Sequences the 8-bit keycode held in the SoC keycode PIO register into discrete key events for the game logic: press, auto-repeat and release. It sits between the keycode PIO output port and the tower-placement/menu FSMs. Events are buffered in a small FIFO and handed off on a valid/ready handshake, so consumers never poll or miss a transition.

## Interface
- HOLD_CYCLES, 25000000: cycles from PRESS to first REPEAT (0.5 s at 50 MHz); ≥2.
- REPEAT_CYCLES, 5000000: cycles between successive REPEATs; ≥2.
- FIFO_DEPTH, 4: event FIFO entries; power of two, ≥2.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- keycode  in  8  current keycode from PIO; 0x00 = no key; synchronous to clk.
- evt_ready  in  1  consumer accepts head event this cycle.
- clear_overflow  in  1  clears overflow flag.
- evt_valid  out  1  FIFO non-empty; head event presented.
- evt_code  out  8  keycode of head event.
- evt_kind  out  2  00 PRESS, 01 REPEAT, 10 RELEASE; 11 never produced.
- overflow  out  1  sticky: an event was dropped because FIFO was full.

## Operation
- Registers: state, cur_code[7:0], cnt (width ceil(log2(max(HOLD_CYCLES,REPEAT_CYCLES)))), FIFO storage, pointers, count, overflow.
- States: IDLE, DELAY, REPEAT.
- IDLE: keycode≠0 → push PRESS(keycode), cur_code←keycode, cnt←0, go DELAY. keycode=0 → stay.
- DELAY: keycode≠cur_code (incl. 0) → push RELEASE(cur_code), go IDLE. Else if cnt=HOLD_CYCLES−1 → push REPEAT(cur_code), cnt←0, go REPEAT. Else cnt←cnt+1.
- REPEAT: keycode≠cur_code → push RELEASE(cur_code), go IDLE. Else if cnt=REPEAT_CYCLES−1 → push REPEAT(cur_code), cnt←0. Else cnt←cnt+1.
- Release has priority over a REPEAT due the same cycle.
- Direct key change A→B: RELEASE(A) this cycle, IDLE, PRESS(B) next cycle. At most one push per cycle.
- FIFO: first-word-fall-through; evt_code/evt_kind show head whenever evt_valid=1, undefined-but-stable otherwise (drive 0 when empty).
- Pop when evt_valid & evt_ready. Push when FSM emits and (not full, or pop same cycle). Full + push + pop → both occur, count unchanged.
- Push while full without pop → event dropped, overflow←1. FSM proceeds as if pushed (state/cnt update unaffected).
- overflow: set on drop, cleared by clear_overflow; set wins on coincidence.
- evt_ready while empty: ignored. Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset (async assert, sync deassert by system): state IDLE, cur_code 0, cnt 0, FIFO empty, evt_valid 0, evt_code 0, evt_kind 0, overflow 0. Reset mid-hold discards all queued events; no RELEASE emitted.
- Latency: keycode change sampled at edge k → event written at edge k → evt_valid=1 after edge k (1 cycle from input change), if FIFO was empty.
- Push into empty FIFO with simultaneous evt_ready: no bypass; event appears next cycle.
- PRESS at edge k → first REPEAT at edge k+HOLD_CYCLES → subsequent REPEATs every REPEAT_CYCLES edges.
- Throughput: one pop per cycle; evt_valid may stay high back-to-back.

## Test plan
(HOLD_CYCLES=4, REPEAT_CYCLES=2, FIFO_DEPTH=4, evt_ready=1 unless stated.)
- Reset: drive keycode=0x1A during reset_n=0 → all outputs 0; after release with 0x1A held, PRESS 0x1A valid one cycle later.
- Tap: keycode 0x1A for 1 cycle then 0x00 → exactly PRESS(0x1A), RELEASE(0x1A), no REPEAT.
- Hold: keycode 0x04 at edges 0–9, 0x00 at edge 10 → pushes at edges 0,4,6,8,10: PRESS, REPEAT×3, RELEASE, all code 0x04.
- Change: 0x04 held 2 cycles then 0x05 → RELEASE(0x04) then PRESS(0x05) on consecutive cycles.
- Backpressure: evt_ready=0, produce 6 events (three taps) → 4 retained, overflow=1; raise evt_ready → PRESS/RELEASE/PRESS/RELEASE drained in order; pulse clear_overflow → 0; full+push+pop in same cycle → no drop.
- Mid-hold reset: assert reset_n=0 during REPEAT with 3 queued → evt_valid 0 immediately, FIFO empty, overflow 0.
